// File: rtl/pipeline_controller.sv
// pipeline_controller
//   Control unit for the 19-bit pipelined datapath. Decodes the ID-stage
//   instruction plus the C/Z flags into the datapath control word, and owns
//   hazard handling: flag-hazard stall (branch behind a flag writer), load-use
//   stall, and IF_ID flush on taken control transfers.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   IF_ID_instruction   ID-stage instruction word
//   C, Z                architectural carry / zero flags
//   mem_write           STM store enable
//   reg_write           register-file write enable
//   push, pop           stack push (JSB) / pop (RET)
//   alu_use_carry       ALU carry-in taken from C
//   alu_op              ALU operation
//   pc_mux              00 pc+1, 01 pc+offset, 10 absolute, 11 stack_out
//   reg_write_mux       00 ALU, 01 shifter, 10 memory
//   alu_in_mux          1 = immediate operand
//   reg_B_mux           1 = read port B addressed by [13:11]
//   select_c, select_z  1 = flag sourced from shifter
//   write_c, write_z    flag update enables
//   stall               hold PC and IF_ID
//   flush               zero IF_ID on next edge
module pipeline_controller #(
    parameter int unsigned INST_W        = 19,
    parameter bit          LOAD_STALL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INST_W-1:0] IF_ID_instruction,
    input  logic              C,
    input  logic              Z,
    output logic              mem_write,
    output logic              reg_write,
    output logic              push,
    output logic              pop,
    output logic              alu_use_carry,
    output logic [2:0]        alu_op,
    output logic [1:0]        pc_mux,
    output logic [1:0]        reg_write_mux,
    output logic              alu_in_mux,
    output logic              reg_B_mux,
    output logic              select_c,
    output logic              select_z,
    output logic              write_c,
    output logic              write_z,
    output logic              stall,
    output logic              flush
);

    typedef enum logic {RUN, STALL} state_t;

    state_t     state, state_next;

    // Shadow of the word issued to ID_EX
    logic       ex_wflags;
    logic       ex_load;
    logic [2:0] ex_rd;

    logic [2:0] rd, rs, rt;
    logic       valid, is_branch, is_ldm, cond_true;
    logic       reads_rs, reads_rt, reads_rd;
    logic       flag_hz, load_hz, hazard;

    // Immediate/offset low bits belong to the datapath only.
    logic       unused_imm_bits;
    assign unused_imm_bits = ^IF_ID_instruction[4:0];

    assign rd = IF_ID_instruction[13:11];
    assign rs = IF_ID_instruction[10:8];
    assign rt = IF_ID_instruction[7:5];

    always_comb begin
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        alu_use_carry = 1'b0;
        alu_op        = '0;
        pc_mux        = '0;
        reg_write_mux = '0;
        alu_in_mux    = 1'b0;
        reg_B_mux     = 1'b0;
        select_c      = 1'b0;
        select_z      = 1'b0;
        write_c       = 1'b0;
        write_z       = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        valid         = 1'b0;
        is_branch     = 1'b0;
        is_ldm        = 1'b0;
        cond_true     = 1'b0;
        reads_rs      = 1'b0;
        reads_rt      = 1'b0;
        reads_rd      = 1'b0;
        flag_hz       = 1'b0;
        load_hz       = 1'b0;
        hazard        = 1'b0;
        state_next    = RUN;

        // The all-zero word is the bubble, even though it looks like an R-type ADD.
        if (IF_ID_instruction != '0) begin
            if (!IF_ID_instruction[18]) begin
                // R-type ([17]=0) and immediate ([17]=1) ALU
                valid         = 1'b1;
                alu_op        = IF_ID_instruction[16:14];
                reg_write     = 1'b1;
                write_c       = 1'b1;
                write_z       = 1'b1;
                alu_use_carry = (IF_ID_instruction[16:14] == 3'b001) ||
                                (IF_ID_instruction[16:14] == 3'b011);
                alu_in_mux    = IF_ID_instruction[17];
                reads_rs      = 1'b1;
                reads_rt      = !IF_ID_instruction[17];
            end else begin
                case (IF_ID_instruction[17:16])
                    2'b00: begin
                        if (!IF_ID_instruction[15]) begin
                            valid      = 1'b1;
                            alu_in_mux = 1'b1;
                            reads_rs   = 1'b1;
                            if (!IF_ID_instruction[14]) begin
                                is_ldm        = 1'b1;
                                reg_write     = 1'b1;
                                reg_write_mux = 2'b10;
                            end else begin
                                mem_write = 1'b1;
                                reg_B_mux = 1'b1;
                                reads_rd  = 1'b1;
                            end
                        end
                    end
                    2'b01: begin
                        valid     = 1'b1;
                        is_branch = 1'b1;
                        case (IF_ID_instruction[15:14])
                            2'b00:   cond_true = Z;
                            2'b01:   cond_true = !Z;
                            2'b10:   cond_true = C;
                            default: cond_true = !C;
                        endcase
                        if (cond_true) begin
                            pc_mux = 2'b01;
                            flush  = 1'b1;
                        end
                    end
                    2'b10: begin
                        valid         = 1'b1;
                        reg_write     = 1'b1;
                        reg_write_mux = 2'b01;
                        write_c       = 1'b1;
                        write_z       = 1'b1;
                        select_c      = 1'b1;
                        select_z      = 1'b1;
                        reads_rs      = 1'b1;
                    end
                    default: begin
                        case (IF_ID_instruction[15:14])
                            2'b00: begin
                                valid  = 1'b1;
                                pc_mux = 2'b10;
                                flush  = 1'b1;
                            end
                            2'b01: begin
                                valid  = 1'b1;
                                pc_mux = 2'b10;
                                push   = 1'b1;
                                flush  = 1'b1;
                            end
                            2'b10: begin
                                valid  = 1'b1;
                                pc_mux = 2'b11;
                                pop    = 1'b1;
                                flush  = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
        end

        flag_hz = is_branch && ex_wflags;
        load_hz = LOAD_STALL_EN && ex_load &&
                  ((reads_rs && (rs == ex_rd)) ||
                   (reads_rt && (rt == ex_rd)) ||
                   (reads_rd && (rd == ex_rd)));
        // The bubble issued while stalling clears the shadow, so a hazard can
        // never hold for two cycles; the STALL state makes that explicit.
        hazard  = (state == RUN) && (flag_hz || load_hz);

        if (hazard) begin
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            push          = 1'b0;
            pop           = 1'b0;
            alu_use_carry = 1'b0;
            alu_op        = '0;
            pc_mux        = '0;
            reg_write_mux = '0;
            alu_in_mux    = 1'b0;
            reg_B_mux     = 1'b0;
            select_c      = 1'b0;
            select_z      = 1'b0;
            write_c       = 1'b0;
            write_z       = 1'b0;
            flush         = 1'b0;
            stall         = 1'b1;
            state_next    = STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            ex_wflags <= 1'b0;
            ex_load   <= 1'b0;
            ex_rd     <= '0;
        end else begin
            state     <= state_next;
            ex_wflags <= write_c | write_z;
            ex_load   <= is_ldm && !hazard;
            ex_rd     <= (valid && !hazard) ? rd : '0;
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
module tb_pipeline_controller;

    typedef struct packed {
        logic       mem_write;
        logic       reg_write;
        logic       push;
        logic       pop;
        logic       alu_use_carry;
        logic [2:0] alu_op;
        logic [1:0] pc_mux;
        logic [1:0] reg_write_mux;
        logic       alu_in_mux;
        logic       reg_B_mux;
        logic       select_c;
        logic       select_z;
        logic       write_c;
        logic       write_z;
        logic       stall;
        logic       flush;
    } ctl_t;

    typedef struct {
        logic [18:0] instr;
        logic        c;
        logic        z;
        logic        rst;
        logic        ld;     // stall expected only because of a load-use hazard
        ctl_t        exp;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] IF_ID_instruction = '0;
    logic        C = 1'b0;
    logic        Z = 1'b0;

    logic       mem_write, reg_write, push, pop, alu_use_carry;
    logic [2:0] alu_op;
    logic [1:0] pc_mux, reg_write_mux;
    logic       alu_in_mux, reg_B_mux, select_c, select_z, write_c, write_z, stall, flush;

    logic       n_mem_write, n_reg_write, n_push, n_pop, n_alu_use_carry;
    logic [2:0] n_alu_op;
    logic [1:0] n_pc_mux, n_reg_write_mux;
    logic       n_alu_in_mux, n_reg_B_mux, n_select_c, n_select_z, n_write_c, n_write_z;
    logic       n_stall, n_flush;

    int tests = 0;
    int fails = 0;

    vec_t vecs[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    pipeline_controller #(.INST_W(19), .LOAD_STALL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .IF_ID_instruction(IF_ID_instruction), .C(C), .Z(Z),
        .mem_write(mem_write), .reg_write(reg_write), .push(push), .pop(pop),
        .alu_use_carry(alu_use_carry), .alu_op(alu_op), .pc_mux(pc_mux),
        .reg_write_mux(reg_write_mux), .alu_in_mux(alu_in_mux), .reg_B_mux(reg_B_mux),
        .select_c(select_c), .select_z(select_z), .write_c(write_c), .write_z(write_z),
        .stall(stall), .flush(flush)
    );

    pipeline_controller #(.INST_W(19), .LOAD_STALL_EN(1'b0)) dut_nls (
        .clk(clk), .reset(reset), .IF_ID_instruction(IF_ID_instruction), .C(C), .Z(Z),
        .mem_write(n_mem_write), .reg_write(n_reg_write), .push(n_push), .pop(n_pop),
        .alu_use_carry(n_alu_use_carry), .alu_op(n_alu_op), .pc_mux(n_pc_mux),
        .reg_write_mux(n_reg_write_mux), .alu_in_mux(n_alu_in_mux), .reg_B_mux(n_reg_B_mux),
        .select_c(n_select_c), .select_z(n_select_z), .write_c(n_write_c), .write_z(n_write_z),
        .stall(n_stall), .flush(n_flush)
    );

    function automatic ctl_t k_none();
        return '0;
    endfunction

    function automatic ctl_t k_stall();
        ctl_t e = '0;
        e.stall = 1'b1;
        return e;
    endfunction

    function automatic ctl_t k_alu(input logic [2:0] op, input logic imm, input logic carry);
        ctl_t e = '0;
        e.alu_op        = op;
        e.reg_write     = 1'b1;
        e.write_c       = 1'b1;
        e.write_z       = 1'b1;
        e.alu_in_mux    = imm;
        e.alu_use_carry = carry;
        return e;
    endfunction

    function automatic ctl_t k_ldm();
        ctl_t e = '0;
        e.alu_in_mux    = 1'b1;
        e.reg_write     = 1'b1;
        e.reg_write_mux = 2'b10;
        return e;
    endfunction

    function automatic ctl_t k_stm();
        ctl_t e = '0;
        e.alu_in_mux = 1'b1;
        e.mem_write  = 1'b1;
        e.reg_B_mux  = 1'b1;
        return e;
    endfunction

    function automatic ctl_t k_shift();
        ctl_t e = '0;
        e.reg_write     = 1'b1;
        e.reg_write_mux = 2'b01;
        e.write_c       = 1'b1;
        e.write_z       = 1'b1;
        e.select_c      = 1'b1;
        e.select_z      = 1'b1;
        return e;
    endfunction

    function automatic ctl_t k_pc(input logic [1:0] pm, input logic ps, input logic pp);
        ctl_t e = '0;
        e.pc_mux = pm;
        e.flush  = 1'b1;
        e.push   = ps;
        e.pop    = pp;
        return e;
    endfunction

    function automatic vec_t mk(input logic [18:0] instr, input logic c, input logic z,
                                input logic rst, input logic ld, input ctl_t exp,
                                input string name);
        vec_t v;
        v.instr = instr; v.c = c; v.z = z; v.rst = rst; v.ld = ld;
        v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, then compare at the falling edge.
    task automatic step(input vec_t v);
        vec_t e;
        ctl_t act;
        @(posedge clk);
        #1;
        reset = v.rst;
        IF_ID_instruction = v.instr;
        C = v.c;
        Z = v.z;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        act = {mem_write, reg_write, push, pop, alu_use_carry, alu_op, pc_mux,
               reg_write_mux, alu_in_mux, reg_B_mux, select_c, select_z,
               write_c, write_z, stall, flush};
        tests++;
        if (act !== e.exp) begin
            fails++;
            $display("FAIL %s: got ctl=%05h expected ctl=%05h", e.name, act, e.exp);
        end
        check_bit({e.name, "/nls_stall"}, n_stall, e.exp.stall & ~e.ld);
        check_bit({e.name, "/stall_flush_excl"}, stall & flush, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(mk(19'h00000, 0, 0, 1, 0, k_none(),                 "reset"));
        vecs.push_back(mk(19'h00000, 0, 0, 0, 0, k_none(),                 "post_reset"));
        vecs.push_back(mk(19'h00A60, 0, 1, 0, 0, k_alu(3'b000, 0, 0),      "add"));
        vecs.push_back(mk(19'h50004, 0, 1, 0, 0, k_stall(),                "bz_flag_stall"));
        vecs.push_back(mk(19'h50004, 0, 1, 0, 0, k_pc(2'b01, 0, 0),        "bz_taken"));
        vecs.push_back(mk(19'h00000, 0, 0, 0, 0, k_none(),                 "nop1"));
        vecs.push_back(mk(19'h00000, 0, 0, 0, 0, k_none(),                 "nop2"));
        vecs.push_back(mk(19'h50004, 0, 0, 0, 0, k_none(),                 "bz_not_taken"));
        vecs.push_back(mk(19'h42210, 0, 0, 0, 0, k_ldm(),                  "ldm_r4"));
        vecs.push_back(mk(19'h00C60, 0, 0, 0, 1, k_stall(),                "add_r4_load_stall"));
        vecs.push_back(mk(19'h00C60, 0, 0, 0, 0, k_alu(3'b000, 0, 0),      "add_r4_issue"));
        vecs.push_back(mk(19'h74123, 0, 0, 0, 0, k_pc(2'b10, 1, 0),        "jsb"));
        vecs.push_back(mk(19'h78000, 0, 0, 0, 0, k_pc(2'b11, 0, 1),        "ret"));
        vecs.push_back(mk(19'h24A05, 1, 0, 0, 0, k_alu(3'b001, 1, 1),      "adc_imm"));
        vecs.push_back(mk(19'h5C008, 1, 0, 0, 0, k_stall(),                "bnc_flag_stall"));
        vecs.push_back(mk(19'h5C008, 1, 0, 0, 0, k_none(),                 "bnc_not_taken"));
        vecs.push_back(mk(19'h58008, 1, 0, 0, 0, k_pc(2'b01, 0, 0),        "bc_taken"));
        vecs.push_back(mk(19'h65200, 0, 0, 0, 0, k_shift(),                "shift"));
        vecs.push_back(mk(19'h44A00, 0, 0, 0, 0, k_stm(),                  "stm_after_shift"));
        vecs.push_back(mk(19'h42900, 0, 0, 0, 0, k_ldm(),                  "ldm_r5"));
        vecs.push_back(mk(19'h46800, 0, 0, 0, 1, k_stall(),                "stm_rd_load_stall"));
        vecs.push_back(mk(19'h46800, 0, 0, 0, 0, k_stm(),                  "stm_issue"));
        vecs.push_back(mk(19'h42900, 0, 0, 0, 0, k_ldm(),                  "ldm_r5_again"));
        vecs.push_back(mk(19'h50004, 0, 1, 0, 0, k_pc(2'b01, 0, 0),        "bz_after_load"));
        vecs.push_back(mk(19'h7C000, 0, 0, 0, 0, k_none(),                 "bad_jump_nop"));
        vecs.push_back(mk(19'h48000, 0, 0, 0, 0, k_none(),                 "bad_mem_nop"));

        // Hold reset across two edges so every register starts known.
        reset = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) step(vecs[i]);

        // Reset during the cycle after a flag stall: the ADD presented under
        // reset must not reach the shadow, so the branch then resolves at once.
        step(mk(19'h00A60, 0, 1, 0, 0, k_alu(3'b000, 0, 0), "rs1_add"));
        step(mk(19'h50004, 0, 1, 0, 0, k_stall(),           "rs1_bz_stall"));
        step(mk(19'h00A60, 0, 1, 1, 0, k_alu(3'b000, 0, 0), "rs1_add_in_reset"));
        step(mk(19'h50004, 0, 1, 0, 0, k_pc(2'b01, 0, 0),   "rs1_bz_no_stall"));

        // Reset asserted in the stall cycle itself.
        step(mk(19'h00A60, 0, 1, 0, 0, k_alu(3'b000, 0, 0), "rs2_add"));
        step(mk(19'h50004, 0, 1, 1, 0, k_stall(),           "rs2_bz_stall_reset"));
        step(mk(19'h50004, 0, 1, 0, 0, k_pc(2'b01, 0, 0),   "rs2_bz_taken"));

        // Load-use on rt only, with rs not matching.
        step(mk(19'h42900, 0, 0, 0, 0, k_ldm(),             "ld_rt_ldm_r5"));
        step(mk(19'h008A0, 0, 0, 0, 1, k_stall(),           "ld_rt_add_stall"));
        step(mk(19'h008A0, 0, 0, 0, 0, k_alu(3'b000, 0, 0), "ld_rt_add_issue"));

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
